imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe_if.sv | 33 +++
 rtl/imm_gen_pipe.sv | 145 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if
//   Handshake bundle between the decode front end and imm_gen_pipe.
//   Input side : in_valid, in_ready, instruction[31:0], in_tag[TAG_W-1:0]
//   Output side: out_valid, out_ready, immediate[XLEN-1:0], fmt[2:0],
//                illegal, out_tag[TAG_W-1:0]
//   master: instruction producer and result consumer (drives the valid and
//           ready inputs of the block).
//   slave : the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immediate;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, instruction, in_tag, out_ready,
        input  in_ready, out_valid, immediate, fmt, illegal, out_tag
    );

    modport slave (
        input  in_valid, instruction, in_tag, out_ready,
        output in_ready, out_valid, immediate, fmt, illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decode-stage immediate generator. Classifies the RV32I/RV64I encoding
//   format of one instruction per cycle and produces the sign-extended
//   immediate through a single back-pressurable output register.
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     bus (slave)         valid/ready input (instruction, in_tag) and
//                         registered output (immediate, fmt, illegal, out_tag)
//     illegal_count[15:0] saturating count of accepted illegal opcodes,
//                         present only when IMMGEN_ILLEGAL_CNT_EN is defined
//   Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    imm_gen_pipe_if.slave bus
`ifdef IMMGEN_ILLEGAL_CNT_EN
    ,
    output logic [15:0]  illegal_count
`endif
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_SHAMT = 3'd6, FMT_NONE = 3'd7;

    logic [31:0] ins;
    logic [31:0] dec_imm32;   // immediate before extension to XLEN
    logic [2:0]  dec_fmt;
    logic        dec_illegal;
    logic        in_ready;
    logic        load;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [2:0]       fmt_q, fmt_d;
    logic             illegal_q, illegal_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign ins = bus.instruction;

    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0010011: begin
                // funct3 001/101 are the shifts; their bits [13:12] are 01
                if (ins[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) dec_imm32 = {26'b0, ins[25:20]};
                    else            dec_imm32 = {27'b0, ins[24:20]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: dec_fmt = FMT_R;
            default:                dec_illegal = 1'b1;
        endcase
    end

    // Output register can take a new word when empty or being drained.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        fmt_d       = fmt_q;
        illegal_d   = illegal_q;
        tag_d       = tag_q;
        if (load) begin
            out_valid_d = 1'b1;
            // 32-bit value already carries instr[31] in its MSB for signed
            // formats; the signed cast replicates it up to XLEN-1.
            imm_d       = XLEN'($signed(dec_imm32));
            fmt_d       = dec_fmt;
            illegal_d   = dec_illegal;
            tag_d       = bus.in_tag;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            fmt_q       <= '0;
            illegal_q   <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.immediate = imm_q;
    assign bus.fmt       = fmt_q;
    assign bus.illegal   = illegal_q;
    assign bus.out_tag   = tag_q;

`ifdef IMMGEN_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (load && dec_illegal && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_cnt_q <= '0;
        else       illegal_cnt_q <= illegal_cnt_d;
    end

    assign illegal_count = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
//   compares both against a behavioural decode model and a one-slot
//   result queue. Directed vectors pin the model, then randomized traffic
//   with random back-pressure follows, then a mid-transfer reset.
//   With IMMGEN_ILLEGAL_CNT_EN defined, the illegal counter is also checked.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

`ifdef IMMGEN_ILLEGAL_CNT_EN
    logic [15:0] cnt32, cnt64;
    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset(reset), .bus(b32), .illegal_count(cnt32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .bus(b64), .illegal_count(cnt64));
`else
    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .bus(b64));
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sx(input longint raw, input int bits);
        if (raw >= (longint'(1) << (bits - 1))) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    function automatic void ref_decode(input logic [31:0] w, input bit x64,
                                       output logic [63:0] imm, output logic [2:0] f,
                                       output logic ill);
        longint v;
        v = 0; f = 3'd7; ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h67, 7'h73: begin f = 3'd1; v = sx(longint'(w[31:20]), 12); end
            7'h13: begin
                if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
                    f = 3'd6;
                    v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
                end else begin
                    f = 3'd1; v = sx(longint'(w[31:20]), 12);
                end
            end
            7'h23: begin f = 3'd2; v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12); end
            7'h63: begin
                f = 3'd3;
                v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                       + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin f = 3'd4; v = sx(longint'(w[31:12]) * 4096, 32); end
            7'h6F: begin
                f = 3'd5;
                v = sx(longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096
                       + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            end
            7'h33, 7'h3B: f = 3'd0;
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
    endfunction

    typedef struct packed {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [2:0]  f;
        logic        ill;
        logic [4:0]  tag;
    } res_t;

    res_t        exp_q[$];     // results waiting to be taken by the consumer
    res_t        last = '0;    // most recently accepted result
    logic [15:0] m_cnt = '0;

    always @(posedge clk or posedge reset) begin
        bit   acc;
        res_t r;
        if (reset) begin
            exp_q.delete();
            last  <= '0;
            m_cnt <= '0;
        end else begin
            acc = b32.in_valid && (exp_q.size() == 0 || b32.out_ready);
            if (b32.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                ref_decode(b32.instruction, 1'b0, r.i32, r.f, r.ill);
                ref_decode(b32.instruction, 1'b1, r.i64, r.f, r.ill);
                r.i32 = {32'b0, r.i32[31:0]};
                r.tag = b32.in_tag;
                exp_q.push_back(r);
                last <= r;
                if (r.ill && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            end
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        bit ev;
        ev = exp_q.size() != 0;
        chk("out_valid32", 64'(b32.out_valid), 64'(ev));
        chk("out_valid64", 64'(b64.out_valid), 64'(ev));
        chk("in_ready32", 64'(b32.in_ready), 64'(!ev || b32.out_ready));
        chk("in_ready64", 64'(b64.in_ready), 64'(!ev || b64.out_ready));
        chk("imm32", {32'b0, b32.immediate}, last.i32);
        chk("imm64", b64.immediate, last.i64);
        chk("fmt32", 64'(b32.fmt), 64'(last.f));
        chk("fmt64", 64'(b64.fmt), 64'(last.f));
        chk("illegal", 64'(b32.illegal), 64'(last.ill));
        chk("tag32", 64'(b32.out_tag), 64'(last.tag));
        chk("tag64", 64'(b64.out_tag), 64'(last.tag));
`ifdef IMMGEN_ILLEGAL_CNT_EN
        chk("cnt32", 64'(cnt32), 64'(m_cnt));
        chk("cnt64", 64'(cnt64), 64'(m_cnt));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] w, input logic [4:0] t, input logic rdy);
        b32.in_valid = v; b32.instruction = w; b32.in_tag = t; b32.out_ready = rdy;
        b64.in_valid = v; b64.instruction = w; b64.in_tag = t; b64.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                              7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

    logic [31:0] str_in  [4] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    logic [31:0] str_imm [4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    logic [2:0]  str_fmt [4] = '{3'd2, 3'd3, 3'd4, 3'd5};

    initial begin
        logic [63:0] mi;
        logic [2:0]  mf;
        logic        ml;
        logic [31:0] w;

        drive(1'b0, 32'h0, 5'd0, 1'b0);

        // Model pins against hand-derived values
        ref_decode(32'hFFF00093, 1'b1, mi, mf, ml);
        chk("pin_addi", mi, 64'hFFFFFFFFFFFFFFFF); chk("pin_addi_fmt", 64'(mf), 64'd1);
        ref_decode(32'hFE000CE3, 1'b1, mi, mf, ml);
        chk("pin_beq", mi, 64'hFFFFFFFFFFFFFFF8);
        ref_decode(32'h001000EF, 1'b1, mi, mf, ml);
        chk("pin_jal", mi, 64'h800);
        ref_decode(32'h4030D093, 1'b0, mi, mf, ml);
        chk("pin_srai", mi, 64'h3); chk("pin_srai_fmt", 64'(mf), 64'd6);
        ref_decode(32'h0000007F, 1'b0, mi, mf, ml);
        chk("pin_ill", 64'(ml), 64'd1); chk("pin_ill_fmt", 64'(mf), 64'd7);

        // Reset values
        @(negedge clk);
        chk("rst_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_imm", b64.immediate, 64'd0);
        chk("rst_tag", 64'(b32.out_tag), 64'd0);
        #1 reset = 1'b0;

        // addi x1,x0,-1
        step();
        drive(1'b1, 32'hFFF00093, 5'd1, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        chk("addi_valid", 64'(b32.out_valid), 64'd1);
        chk("addi_imm32", 64'(b32.immediate), 64'hFFFFFFFF);
        chk("addi_imm64", b64.immediate, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_fmt", 64'(b32.fmt), 64'd1);
        chk("addi_ill", 64'(b32.illegal), 64'd0);

        // Back-to-back stream, one cycle latency each
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, str_in[i], 5'(i + 2), 1'b1);
            step();
            chk("stream_imm", 64'(b32.immediate), 64'(str_imm[i]));
            chk("stream_fmt", 64'(b32.fmt), 64'(str_fmt[i]));
            chk("stream_tag", 64'(b32.out_tag), 64'(i + 2));
        end

        // srai shift amount on both widths
        drive(1'b1, 32'h4030D093, 5'd6, 1'b1);
        step();
        chk("srai_imm32", 64'(b32.immediate), 64'd3);
        chk("srai_imm64", b64.immediate, 64'd3);
        chk("srai_fmt", 64'(b64.fmt), 64'd6);

        // Back-pressure: lui held while a store waits
        drive(1'b1, 32'h123452B7, 5'd7, 1'b1);
        step();
        drive(1'b1, 32'hFE20AE23, 5'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rdy", 64'(b32.in_ready), 64'd0);
            chk("stall_imm", 64'(b32.immediate), 64'h12345000);
            chk("stall_tag", 64'(b32.out_tag), 64'd7);
        end
        drive(1'b1, 32'hFE20AE23, 5'd8, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        chk("resume_imm", 64'(b32.immediate), 64'hFFFFFFFC);
        chk("resume_tag", 64'(b32.out_tag), 64'd8);
        step();
        chk("resume_drain", 64'(b32.out_valid), 64'd0);

        // Unsupported opcode
        drive(1'b1, 32'h0000007F, 5'd3, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        chk("ill_flag", 64'(b32.illegal), 64'd1);
        chk("ill_fmt", 64'(b32.fmt), 64'd7);
        chk("ill_imm", b64.immediate, 64'd0);
`ifdef IMMGEN_ILLEGAL_CNT_EN
        chk("ill_cnt", 64'(cnt32), 64'd1);
        force dut32.illegal_cnt_q = 16'hFFFF;
        force dut64.illegal_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut32.illegal_cnt_q;
        release dut64.illegal_cnt_q;
        drive(1'b1, 32'h0000007F, 5'd4, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        chk("cnt_sat32", 64'(cnt32), 64'hFFFF);
        chk("cnt_sat64", 64'(cnt64), 64'hFFFF);
`endif

        // Randomized traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            if ($urandom_range(0, 6) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            drive(1'($urandom_range(0, 3) != 0), w, 5'($urandom), 1'($urandom_range(0, 3) != 0));
            step();
        end

        // Reset while a result is pending
        drive(1'b1, 32'hFFF00093, 5'd9, 1'b0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(b32.out_valid), 64'd0);
        chk("mid_rst_imm", b64.immediate, 64'd0);
        chk("mid_rst_fmt", 64'(b32.fmt), 64'd0);
        chk("mid_rst_tag", 64'(b64.out_tag), 64'd0);
        chk("mid_rst_rdy", 64'(b32.in_ready), 64'd1);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_accept", 64'(b32.out_valid), 64'd1);
        chk("post_rst_tag", 64'(b32.out_tag), 64'd9);
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
